// File: rtl/se_global_avg_pool.sv
// Squeeze stage of the SE block: averages every channel of an H x W x C frame,
// summing one spatial row per clock, then divides by H*W and saturates.
module se_global_avg_pool #(
  parameter int CHANNELS   = 16,
  parameter int IN_HEIGHT  = 14,
  parameter int IN_WIDTH   = 14,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] data_in [0:IN_HEIGHT-1][0:IN_WIDTH-1][0:CHANNELS-1],
  input  logic                         valid_in,
  output logic                         ready,
  output logic signed [DATA_WIDTH-1:0] data_out [0:CHANNELS-1],
  output logic                         valid_out
);

  localparam int N         = IN_HEIGHT * IN_WIDTH;
  localparam int ACC_WIDTH = DATA_WIDTH + $clog2(N) + 1;
  localparam int ROW_W     = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;

  localparam logic [ROW_W-1:0]            LAST_ROW = ROW_W'(IN_HEIGHT - 1);
  localparam logic signed [ACC_WIDTH-1:0] N_DIV    = ACC_WIDTH'(N);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX  = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [ROW_W-1:0]              row_reg;
  logic signed [DATA_WIDTH-1:0]  frame_reg [0:IN_HEIGHT-1][0:IN_WIDTH-1][0:CHANNELS-1];
  logic signed [ACC_WIDTH-1:0]   acc_reg   [0:CHANNELS-1];
  logic signed [ACC_WIDTH-1:0]   row_sum   [0:CHANNELS-1];
  logic signed [DATA_WIDTH-1:0]  mean_sat  [0:CHANNELS-1];

  assign ready = (state_reg == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (valid_in) state_next = ACCUM;
      ACCUM:   if (row_reg == LAST_ROW) state_next = DIVIDE;
      DIVIDE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic signed [ACC_WIDTH-1:0] sum_c;
      logic signed [ACC_WIDTH-1:0] quot_c;

      // Samples are sign-extended before the adder chain so the sum cannot wrap.
      always_comb begin
        sum_c = '0;
        for (int w = 0; w < IN_WIDTH; w++) begin
          sum_c = sum_c + ACC_WIDTH'(frame_reg[row_reg][w][gi]);
        end
      end
      assign row_sum[gi] = sum_c;

      // Signed division by a constant truncates toward zero.
      assign quot_c = acc_reg[gi] / N_DIV;
      assign mean_sat[gi] = (quot_c > SAT_MAX) ? SAT_MAX[DATA_WIDTH-1:0] :
                            (quot_c < SAT_MIN) ? SAT_MIN[DATA_WIDTH-1:0] :
                                                 quot_c[DATA_WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_reg   <= '0;
      valid_out <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_reg[c]  <= '0;
        data_out[c] <= '0;
      end
      for (int h = 0; h < IN_HEIGHT; h++) begin
        for (int w = 0; w < IN_WIDTH; w++) begin
          for (int c = 0; c < CHANNELS; c++) begin
            frame_reg[h][w][c] <= '0;
          end
        end
      end
    end else begin
      valid_out <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (valid_in) begin
            frame_reg <= data_in;
            row_reg   <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
              acc_reg[c] <= '0;
            end
          end
        end
        ACCUM: begin
          for (int c = 0; c < CHANNELS; c++) begin
            acc_reg[c] <= acc_reg[c] + row_sum[c];
          end
          if (row_reg != LAST_ROW) begin
            row_reg <= row_reg + ROW_W'(1);
          end
        end
        DIVIDE: begin
          for (int c = 0; c < CHANNELS; c++) begin
            data_out[c] <= mean_sat[c];
          end
          valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_se_global_avg_pool.sv
// Bench for se_global_avg_pool: a 2x2x2 instance and a default 14x14x16 instance,
// with expected means and arrival cycles queued at accept time and checked on valid_out.
module tb_se_global_avg_pool;

  localparam int HS = 2;
  localparam int HL = 14;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  logic signed [7:0] din_s [0:1][0:1][0:1];
  logic              vin_s;
  logic              rdy_s;
  logic signed [7:0] dout_s [0:1];
  logic              vo_s;

  logic signed [7:0] din_l [0:13][0:13][0:15];
  logic              vin_l;
  logic              rdy_l;
  logic signed [7:0] dout_l [0:15];
  logic              vo_l;

  int q_s_cyc[$];
  int q_s_e0[$];
  int q_s_e1[$];
  int q_l_cyc[$];
  int q_l_e[$];

  se_global_avg_pool #(.CHANNELS(2), .IN_HEIGHT(HS), .IN_WIDTH(2), .DATA_WIDTH(8)) dut_s (
    .clk(clk), .rst(rst), .data_in(din_s), .valid_in(vin_s),
    .ready(rdy_s), .data_out(dout_s), .valid_out(vo_s)
  );

  se_global_avg_pool #(.CHANNELS(16), .IN_HEIGHT(HL), .IN_WIDTH(14), .DATA_WIDTH(8)) dut_l (
    .clk(clk), .rst(rst), .data_in(din_l), .valid_in(vin_l),
    .ready(rdy_l), .data_out(dout_l), .valid_out(vo_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_s(input int v0, input int v1);
    for (int h = 0; h < 2; h++)
      for (int w = 0; w < 2; w++) begin
        din_s[h][w][0] = 8'(v0);
        din_s[h][w][1] = 8'(v1);
      end
  endtask

  task automatic fill_l(input int v);
    for (int h = 0; h < 14; h++)
      for (int w = 0; w < 14; w++)
        for (int c = 0; c < 16; c++)
          din_l[h][w][c] = 8'(v);
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the accept edge.
  task automatic accept_s(input int e0, input int e1);
    check("s_ready_at_accept", int'(rdy_s), 1);
    vin_s = 1'b1;
    @(posedge clk); #1;
    q_s_cyc.push_back(cyc + HS + 1);
    q_s_e0.push_back(e0);
    q_s_e1.push_back(e1);
    vin_s = 1'b0;
  endtask

  task automatic accept_l(input int e, input bit expect_result);
    check("l_ready_at_accept", int'(rdy_l), 1);
    vin_l = 1'b1;
    @(posedge clk); #1;
    if (expect_result) begin
      q_l_cyc.push_back(cyc + HL + 1);
      q_l_e.push_back(e);
    end
    vin_l = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (vo_s) begin
      if (q_s_cyc.size() == 0) begin
        check("s_unexpected_valid_out", 1, 0);
      end else begin
        int ec, e0, e1;
        ec = q_s_cyc.pop_front();
        e0 = q_s_e0.pop_front();
        e1 = q_s_e1.pop_front();
        check("s_valid_out_cycle", cyc, ec);
        check("s_mean_ch0", int'(dout_s[0]), e0);
        check("s_mean_ch1", int'(dout_s[1]), e1);
        $display("small frame out @%0d: ch0=%0d ch1=%0d", cyc, dout_s[0], dout_s[1]);
      end
    end
    if (vo_l) begin
      if (q_l_cyc.size() == 0) begin
        check("l_unexpected_valid_out", 1, 0);
      end else begin
        int ec, e;
        ec = q_l_cyc.pop_front();
        e  = q_l_e.pop_front();
        check("l_valid_out_cycle", cyc, ec);
        for (int c = 0; c < 16; c++) check("l_mean", int'(dout_l[c]), e);
        $display("large frame out @%0d: ch0=%0d expected=%0d", cyc, dout_l[0], e);
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    vin_s  = 1'b0;
    vin_l  = 1'b0;
    fill_s(0, 0);
    fill_l(0);
    #2 rst = 1'b1;
    wait_cycles(2);
    check("reset_ready_s", int'(rdy_s), 1);
    check("reset_ready_l", int'(rdy_l), 1);
    check("reset_valid_s", int'(vo_s), 0);
    check("reset_valid_l", int'(vo_l), 0);
    check("reset_dout_s0", int'(dout_s[0]), 0);
    check("reset_dout_l0", int'(dout_l[0]), 0);
    rst = 1'b0;
    wait_cycles(1);

    // constant frame
    fill_s(5, -7);
    accept_s(5, -7);
    check("s_ready_low_in_accum", int'(rdy_s), 0);
    wait_cycles(5);

    // truncation toward zero; input is scrambled after accept
    din_s[0][0][0] = 8'sd3;  din_s[0][1][0] = 8'sd4;  din_s[1][0][0] = -8'sd1; din_s[1][1][0] = 8'sd0;
    din_s[0][0][1] = -8'sd3; din_s[0][1][1] = -8'sd4; din_s[1][0][1] = 8'sd1;  din_s[1][1][1] = 8'sd0;
    accept_s(1, -1);
    fill_s(100, 100);
    wait_cycles(5);

    // extremes
    fill_l(-128);
    accept_l(-128, 1'b1);
    wait_cycles(HL + 2);
    fill_l(127);
    accept_l(127, 1'b1);
    wait_cycles(HL + 2);

    // busy drop, then B at the first ready cycle
    begin
      int a;
      fill_l(10);
      accept_l(10, 1'b1);
      a = cyc;
      wait_cycles(3);
      fill_l(20);
      check("l_ready_low_at_busy_pulse", int'(rdy_l), 0);
      vin_l = 1'b1;
      @(posedge clk); #1;
      vin_l = 1'b0;
      wait_cycles(a + HL + 1 - cyc);
      accept_l(20, 1'b1);
      wait_cycles(HL + 2);
    end

    // mid-frame asynchronous reset
    fill_l(33);
    accept_l(33, 1'b0);
    wait_cycles(2);
    #3 rst = 1'b1;
    #1;
    check("async_rst_ready_l", int'(rdy_l), 1);
    check("async_rst_valid_l", int'(vo_l), 0);
    for (int c = 0; c < 16; c++) check("async_rst_dout_l", int'(dout_l[c]), 0);
    @(posedge clk);
    #4 rst = 1'b0;
    wait_cycles(2 * (HL + 2));
    fill_l(-50);
    accept_l(-50, 1'b1);
    wait_cycles(HL + 2);

    // back-to-back with valid_in held high
    vin_s = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int v;
      v = (k % 2 == 0) ? 1 : -1;
      fill_s(v, v);
      if (k > 0) wait_cycles(HS + 1);
      check("s_b2b_ready", int'(rdy_s), 1);
      @(posedge clk); #1;
      q_s_cyc.push_back(cyc + HS + 1);
      q_s_e0.push_back(v);
      q_s_e1.push_back(v);
      fill_s(-v, -v);
    end
    vin_s = 1'b0;
    wait_cycles(10);

    check("s_pending_results", q_s_cyc.size(), 0);
    check("l_pending_results", q_l_cyc.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/se_global_avg_pool.md
# se_global_avg_pool

Squeeze stage of the MobileNetV3-small squeeze-and-excitation (SE) path. It sits directly downstream of the depthwise convolution stage and consumes that stage's saturated output tensor (`data_out`/`valid_out`). It reduces each channel of an H×W×C frame to one mean value by accumulating one spatial row per clock. The per-channel means it produces feed the SE fully-connected layers.

## Interface
- `CHANNELS`, 16: channels per frame; all are reduced in parallel.
- `IN_HEIGHT`, 14: frame rows. Must be ≥ 1.
- `IN_WIDTH`, 14: frame columns. Must be ≥ 1.
- `DATA_WIDTH`, 8: signed fixed-point sample width. Input and output use the same Q format; no fractional-bit shift is applied.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  signed [DATA_WIDTH-1:0] [0:IN_HEIGHT-1][0:IN_WIDTH-1][0:CHANNELS-1]  full frame; sampled only at the accept edge.
- `valid_in`  in  1  frame-valid strobe.
- `ready`  out  1  high when a frame can be accepted.
- `data_out`  out  signed [DATA_WIDTH-1:0] [0:CHANNELS-1]  per-channel mean; held until the next result.
- `valid_out`  out  1  one-cycle pulse marking a new `data_out`.

## Operation
- Internal constants:
  - N = IN_HEIGHT*IN_WIDTH.
  - ACC_WIDTH = DATA_WIDTH + $clog2(N) + 1, signed.
- FSM states: IDLE, ACCUM, DIVIDE. `ready` = (state == IDLE), decoded combinationally.
- **IDLE:** if `valid_in` is high at an edge:
  - the full frame is copied into an internal frame register;
  - row counter is cleared to 0;
  - all per-channel accumulators are cleared to 0;
  - state goes to ACCUM.
- **ACCUM:** each edge adds row[r][0..IN_WIDTH-1][c] into acc[c] for every c.
  - Adder inputs are sign-extended to ACC_WIDTH; an adder tree over IN_WIDTH terms per channel is acceptable.
  - After row IN_HEIGHT-1 is added, state goes to DIVIDE; otherwise the row counter increments.
- **DIVIDE:** one edge.
  - data_out[c] <= acc[c] / N, using signed division truncated toward zero. N is a constant, so a constant divider or reciprocal multiply is acceptable only if it is bit-exact.
  - The quotient is then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. This is defensive only; a mean of in-range samples never saturates.
  - `valid_out` <= 1; state returns to IDLE.
- **`valid_in` while `ready` is low:** ignored. The frame is dropped, with no error flag; upstream must respect `ready`.
- **Frame register:** held during ACCUM, so `data_in` may change after the accept edge.
- **Reset (asynchronous, any state, including mid-ACCUM):**
  - state = IDLE, row counter = 0;
  - accumulators, frame register, every `data_out[c]` and `valid_out` all = 0;
  - `ready` = 1 immediately (combinational from state).
  - A partially accumulated frame is discarded; no `valid_out` is generated for it.

## Timing
- Accept edge E0 (state IDLE, `valid_in`=1).
- ACCUM edges E1..E_H add rows 0..IN_HEIGHT-1.
- DIVIDE at edge E_{H+1}: `data_out` updates and `valid_out` goes high.
- At E_{H+2}, `valid_out` returns to 0.
- Latency from the accept edge to `valid_out` high is IN_HEIGHT+1 clocks.
- `ready` is low from after E0 through the cycle ending at E_{H+1}.
- `ready` is high in the same cycle that `valid_out` is high. A new frame may be accepted at E_{H+2}, giving a minimum frame interval of IN_HEIGHT+2 clocks.
- `valid_out` is never high for two consecutive cycles.
- `data_out` changes only at DIVIDE edges and at reset.

## Test plan
- **Constant frame:** IN_HEIGHT=IN_WIDTH=2, CHANNELS=2, all samples 5 on channel 0 and −7 on channel 1 -> data_out = {5, −7}; `valid_out` high exactly 3 clocks after the accept edge, for one cycle.
- **Truncation toward zero:**
  - channel 0 samples {3,4,−1,0} (sum 6) -> 1;
  - channel 1 samples {−3,−4,1,0} (sum −6) -> −1, not −2.
- **Extremes, default 14×14×16:** all −128 -> every channel −128; all 127 -> every channel 127; no wrap in the accumulators.
- **Busy drop:** accept frame A (all 10), pulse `valid_in` with frame B (all 20) during ACCUM -> `ready`=0 at the B pulse, only one `valid_out` occurs, and its result is 10. Then apply B at the first `ready`=1 cycle -> 20, with a `valid_out` interval of IN_HEIGHT+2.
- **Mid-frame reset:** assert `rst` two clocks into ACCUM -> asynchronously `data_out`=0, `valid_out`=0, `ready`=1. No `valid_out` follows within 2×(IN_HEIGHT+2) clocks unless a new frame is accepted. A frame applied after reset release averages correctly.
- **Back-to-back:** hold `valid_in` high continuously with alternating frames of all 1 and all −1 -> outputs alternate 1, −1, with one `valid_out` every IN_HEIGHT+2 clocks.
